// File: rtl/cpu4004_pkg.sv
// Shared 4004 core definitions: machine-cycle phases, register-file IO modes,
// opcode constants and the two-word instruction classifier.
package cpu4004_pkg;

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_t;

  localparam logic [1:0] IO_WR   = 2'b00;
  localparam logic [1:0] IO_RD   = 2'b01;
  localparam logic [1:0] IO_IDLE = 2'b10;

  localparam logic [3:0] OPR_NOP     = 4'b0000;
  localparam logic [3:0] OPR_JCN     = 4'b0001;
  localparam logic [3:0] OPR_FIM_SRC = 4'b0010;
  localparam logic [3:0] OPR_JUN     = 4'b0100;
  localparam logic [3:0] OPR_JMS     = 4'b0101;
  localparam logic [3:0] OPR_INC     = 4'b0110;
  localparam logic [3:0] OPR_ISZ     = 4'b0111;
  localparam logic [3:0] OPR_LD      = 4'b1010;
  localparam logic [3:0] OPR_XCH     = 4'b1011;

  // FIM and SRC share OPR 0010; OPA[0] separates FIM (0) from SRC (1).
  function automatic logic is_two_word(input logic [3:0] opr,
                                       input logic [3:0] opa);
    logic two;
    two = 1'b0;
    case (opr)
      OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: two = 1'b1;
      OPR_FIM_SRC:                         two = ~opa[0];
      default:                             two = 1'b0;
    endcase
    return two;
  endfunction

endpackage

// File: rtl/machine_cycle_counter.sv
// Eight-phase machine-cycle counter (A1..X3) with a sync flag during X3.
// Shared by the index register, ROM and RAM interface blocks.
module machine_cycle_counter
  import cpu4004_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  output phase_t phase,
  output logic   sync
);

  logic [2:0] phase_nx;

  assign phase_nx = phase + 3'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= PH_A1;
    end else begin
      phase <= phase_t'(phase_nx);
    end
  end

  assign sync = (phase == PH_X3);

endmodule

// File: rtl/index_register_sequencer.sv
// Index register file sequencer: latches instruction nibbles in M1/M2 and
// drives register select, IO mode, write strobe and bus data during X1..X3.
module index_register_sequencer
  import cpu4004_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] data_in,
  input  logic [3:0] acc_in,
  output logic [3:0] data_out,
  output logic       data_oe,
  output logic [3:0] index_register_select,
  output logic [1:0] index_register_IO,
  output logic       index_register_I_WE,
  output logic       acc_load,
  output logic       src_strobe,
  output logic       inc_zero,
  output logic       sync
);

  phase_t     phase;

  logic [3:0] opr, opr_nx;
  logic [3:0] opa, opa_nx;
  logic [3:0] d_hi, d_hi_nx;
  logic [3:0] d_lo, d_lo_nx;
  logic [3:0] temp, temp_nx;
  logic       second_word, second_word_nx;
  logic       inc_zero_q, inc_zero_nx;

  logic       is_inc;
  logic [2:0] pair;

  function automatic logic [3:0] inc_wrap(input logic [3:0] v);
    return v + 4'd1;
  endfunction

  machine_cycle_counter u_cycle (
    .clk   (clk),
    .reset (reset),
    .phase (phase),
    .sync  (sync)
  );

  assign is_inc   = (opr == OPR_INC) || (opr == OPR_ISZ);
  assign pair     = opa[3:1];
  assign inc_zero = inc_zero_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opr         <= OPR_NOP;
      opa         <= 4'd0;
      d_hi        <= 4'd0;
      d_lo        <= 4'd0;
      temp        <= 4'd0;
      second_word <= 1'b0;
      inc_zero_q  <= 1'b0;
    end else begin
      opr         <= opr_nx;
      opa         <= opa_nx;
      d_hi        <= d_hi_nx;
      d_lo        <= d_lo_nx;
      temp        <= temp_nx;
      second_word <= second_word_nx;
      inc_zero_q  <= inc_zero_nx;
    end
  end

  // In a second-word cycle OPR/OPA keep the opener so the X phases still
  // know which instruction (and which FIM pair) they belong to.
  always_comb begin
    opr_nx         = opr;
    opa_nx         = opa;
    d_hi_nx        = d_hi;
    d_lo_nx        = d_lo;
    temp_nx        = temp;
    second_word_nx = second_word;
    inc_zero_nx    = inc_zero_q;
    case (phase)
      PH_M1: begin
        if (second_word) d_hi_nx = data_in;
        else             opr_nx  = data_in;
      end
      PH_M2: begin
        if (second_word) d_lo_nx = data_in;
        else             opa_nx  = data_in;
      end
      PH_X1: begin
        if (!second_word && (is_inc || opr == OPR_XCH)) temp_nx = data_in;
      end
      PH_X2: begin
        if (!second_word && is_inc) inc_zero_nx = (inc_wrap(temp) == 4'd0);
      end
      PH_X3: begin
        second_word_nx = !second_word && is_two_word(opr, opa);
      end
      default: ;
    endcase
  end

  // The bus is never driven in a phase where the register file reads onto it.
  always_comb begin
    index_register_select = 4'd0;
    index_register_IO     = IO_IDLE;
    index_register_I_WE   = 1'b0;
    data_out              = 4'd0;
    data_oe               = 1'b0;
    acc_load              = 1'b0;
    src_strobe            = 1'b0;
    if (second_word) begin
      if (opr == OPR_FIM_SRC) begin
        case (phase)
          PH_X2: begin
            index_register_IO     = IO_WR;
            index_register_I_WE   = 1'b1;
            index_register_select = {pair, 1'b0};
            data_oe               = 1'b1;
            data_out              = d_hi;
          end
          PH_X3: begin
            index_register_IO     = IO_WR;
            index_register_I_WE   = 1'b1;
            index_register_select = {pair, 1'b1};
            data_oe               = 1'b1;
            data_out              = d_lo;
          end
          default: ;
        endcase
      end
    end else begin
      case (opr)
        OPR_LD: begin
          if (phase == PH_X1) begin
            index_register_IO     = IO_RD;
            index_register_select = opa;
            acc_load              = 1'b1;
          end
        end
        OPR_XCH: begin
          case (phase)
            PH_X1: begin
              index_register_IO     = IO_RD;
              index_register_select = opa;
            end
            PH_X2: begin
              index_register_IO     = IO_WR;
              index_register_I_WE   = 1'b1;
              index_register_select = opa;
              data_oe               = 1'b1;
              data_out              = acc_in;
            end
            PH_X3: begin
              data_oe  = 1'b1;
              data_out = temp;
              acc_load = 1'b1;
            end
            default: ;
          endcase
        end
        OPR_INC, OPR_ISZ: begin
          case (phase)
            PH_X1: begin
              index_register_IO     = IO_RD;
              index_register_select = opa;
            end
            PH_X2: begin
              index_register_IO     = IO_WR;
              index_register_I_WE   = 1'b1;
              index_register_select = opa;
              data_oe               = 1'b1;
              data_out              = inc_wrap(temp);
            end
            default: ;
          endcase
        end
        OPR_FIM_SRC: begin
          if (opa[0]) begin
            case (phase)
              PH_X2: begin
                index_register_IO     = IO_RD;
                index_register_select = {pair, 1'b0};
                src_strobe            = 1'b1;
              end
              PH_X3: begin
                index_register_IO     = IO_RD;
                index_register_select = {pair, 1'b1};
                src_strobe            = 1'b1;
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_index_register_sequencer.sv
// Bench for index_register_sequencer: plays ROM, register file and
// accumulator around the DUT and compares every phase with an ISA-level model.
module tb_index_register_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] data_in;
  logic [3:0] acc_in;
  logic [3:0] data_out;
  logic       data_oe;
  logic [3:0] sel;
  logic [1:0] io;
  logic       we;
  logic       acc_load;
  logic       src_strobe;
  logic       inc_zero;
  logic       sync;

  int checks = 0;
  int errors = 0;

  logic [3:0]  rf   [16];
  logic [3:0]  m_rf [16];
  logic [3:0]  m_acc;
  logic        m_zero;
  logic        m_second;
  logic [3:0]  m_fopr;
  logic [3:0]  m_fopa;
  logic [15:0] exp_v [8];

  index_register_sequencer dut (
    .clk                   (clk),
    .reset                 (reset),
    .data_in               (data_in),
    .acc_in                (acc_in),
    .data_out              (data_out),
    .data_oe               (data_oe),
    .index_register_select (sel),
    .index_register_IO     (io),
    .index_register_I_WE   (we),
    .acc_load              (acc_load),
    .src_strobe            (src_strobe),
    .inc_zero              (inc_zero),
    .sync                  (sync)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pack(input logic [1:0] pio, input logic [3:0] psel,
                                       input logic pwe, input logic poe,
                                       input logic [3:0] pdout, input logic pal,
                                       input logic psrc, input logic pz, input logic psy);
    return {pio, psel, pwe, poe, pdout, pal, psrc, pz, psy};
  endfunction

  function automatic logic [15:0] dut_outs();
    return pack(io, sel, we, data_oe, data_out, acc_load, src_strobe, inc_zero, sync);
  endfunction

  // Phase index: 0..7 = A1 A2 A3 M1 M2 X1 X2 X3.
  task automatic build_expect(input logic [3:0] hi, input logic [3:0] lo);
    logic [1:0] e_io   [8];
    logic [3:0] e_sel  [8];
    logic [3:0] e_dout [8];
    logic       e_we [8], e_oe [8], e_al [8], e_src [8];
    logic       z0;
    logic [3:0] old, v;
    logic [2:0] pr;
    for (int p = 0; p < 8; p++) begin
      e_io[p] = 2'b10; e_sel[p] = 4'd0; e_dout[p] = 4'd0;
      e_we[p] = 1'b0;  e_oe[p] = 1'b0;  e_al[p] = 1'b0; e_src[p] = 1'b0;
    end
    z0 = m_zero;
    if (m_second) begin
      if (m_fopr == 4'd2) begin
        pr = m_fopa[3:1];
        e_io[6] = 2'b00; e_we[6] = 1'b1; e_oe[6] = 1'b1; e_sel[6] = {pr, 1'b0}; e_dout[6] = hi;
        e_io[7] = 2'b00; e_we[7] = 1'b1; e_oe[7] = 1'b1; e_sel[7] = {pr, 1'b1}; e_dout[7] = lo;
        m_rf[{pr, 1'b0}] = hi;
        m_rf[{pr, 1'b1}] = lo;
      end
      m_second = 1'b0;
    end else begin
      pr = lo[3:1];
      case (hi)
        4'hA: begin
          e_io[5] = 2'b01; e_sel[5] = lo; e_al[5] = 1'b1;
          m_acc = m_rf[lo];
        end
        4'hB: begin
          old = m_rf[lo];
          e_io[5] = 2'b01; e_sel[5] = lo;
          e_io[6] = 2'b00; e_we[6] = 1'b1; e_oe[6] = 1'b1; e_sel[6] = lo; e_dout[6] = m_acc;
          e_oe[7] = 1'b1; e_dout[7] = old; e_al[7] = 1'b1;
          m_rf[lo] = m_acc;
          m_acc = old;
        end
        4'h6, 4'h7: begin
          v = m_rf[lo] + 4'd1;
          e_io[5] = 2'b01; e_sel[5] = lo;
          e_io[6] = 2'b00; e_we[6] = 1'b1; e_oe[6] = 1'b1; e_sel[6] = lo; e_dout[6] = v;
          m_rf[lo] = v;
          m_zero = (v == 4'd0);
        end
        4'h2: begin
          if (lo[0]) begin
            e_io[6] = 2'b01; e_sel[6] = {pr, 1'b0}; e_src[6] = 1'b1;
            e_io[7] = 2'b01; e_sel[7] = {pr, 1'b1}; e_src[7] = 1'b1;
          end
        end
        default: ;
      endcase
      m_second = (hi == 4'd1) || (hi == 4'd2 && !lo[0]) || (hi == 4'd4) ||
                 (hi == 4'd5) || (hi == 4'd7);
      m_fopr = hi;
      m_fopa = lo;
    end
    for (int p = 0; p < 8; p++)
      exp_v[p] = pack(e_io[p], e_sel[p], e_we[p], e_oe[p], e_dout[p], e_al[p], e_src[p],
                      (p == 7) ? m_zero : z0, (p == 7));
  endtask

  // Entered just after an X3 negedge (or the reset-release sequence).
  task automatic run_cycle(input string tag, input logic [3:0] hi, input logic [3:0] lo);
    logic [15:0] got;
    build_expect(hi, lo);
    for (int p = 0; p < 8; p++) begin
      @(negedge clk);
      got = dut_outs();
      checks++;
      if (got !== exp_v[p]) begin
        errors++;
        $display("FAIL %s ph%0d outputs got %h exp %h (op %h%h)", tag, p, got, exp_v[p], hi, lo);
      end
      checks++;
      if (data_oe === 1'b1 && io === 2'b01) begin
        errors++;
        $display("FAIL %s ph%0d contention got oe=1 io=01 exp not both", tag, p);
      end
      if (p == 3)                 data_in = hi;
      else if (p == 4)            data_in = lo;
      else if (io === 2'b01)      data_in = rf[sel];
      else                        data_in = 4'($urandom);
      if (io === 2'b00 && we === 1'b1) rf[sel] = data_out;
      if (acc_load === 1'b1) acc_in = data_oe ? data_out : data_in;
    end
    checks++;
    if (acc_in !== m_acc) begin
      errors++;
      $display("FAIL %s accumulator got %h exp %h", tag, acc_in, m_acc);
    end
  endtask

  task automatic set_reg(input int n, input logic [3:0] v);
    rf[n] = v;
    m_rf[n] = v;
  endtask

  task automatic set_acc(input logic [3:0] v);
    acc_in = v;
    m_acc = v;
  endtask

  task automatic release_reset();
    @(negedge clk);
    checks++;
    if (dut_outs() !== 16'h8000) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", dut_outs(), 16'h8000);
    end
    reset = 1'b1;
    data_in = 4'd0;
    m_second = 1'b0;
    m_zero = 1'b0;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      data_in = 4'd0;
      checks++;
      if (sync !== (k == 7)) begin
        errors++;
        $display("FAIL sync_after_release k%0d got %b exp %b", k, sync, (k == 7));
      end
    end
  endtask

  task automatic test_inc_wrap();
    set_reg(5, 4'hF);
    run_cycle("inc_r5", 4'h6, 4'h5);
    checks++;
    if (rf[5] !== 4'h0) begin
      errors++;
      $display("FAIL inc_wrap_reg got %h exp %h", rf[5], 4'h0);
    end
    checks++;
    if (inc_zero !== 1'b1) begin
      errors++;
      $display("FAIL inc_zero got %b exp %b", inc_zero, 1'b1);
    end
    run_cycle("inc_r5_again", 4'h6, 4'h5);
    checks++;
    if (inc_zero !== 1'b0) begin
      errors++;
      $display("FAIL inc_zero_clear got %b exp %b", inc_zero, 1'b0);
    end
  endtask

  task automatic test_xch();
    set_reg(3, 4'hA);
    set_acc(4'h6);
    run_cycle("xch_r3", 4'hB, 4'h3);
    checks++;
    if (rf[3] !== 4'h6) begin
      errors++;
      $display("FAIL xch_reg got %h exp %h", rf[3], 4'h6);
    end
    checks++;
    if (acc_in !== 4'hA) begin
      errors++;
      $display("FAIL xch_acc got %h exp %h", acc_in, 4'hA);
    end
  endtask

  task automatic test_src();
    run_cycle("src_p2", 4'h2, 4'h5);
  endtask

  task automatic test_fim();
    run_cycle("fim_p7", 4'h2, 4'hE);
    run_cycle("fim_p7_w2", 4'hC, 4'h3);
    checks++;
    if (rf[14] !== 4'hC) begin
      errors++;
      $display("FAIL fim_r14 got %h exp %h", rf[14], 4'hC);
    end
    checks++;
    if (rf[15] !== 4'h3) begin
      errors++;
      $display("FAIL fim_r15 got %h exp %h", rf[15], 4'h3);
    end
    run_cycle("after_fim_ld", 4'hA, 4'hE);
  endtask

  task automatic test_jun_ld();
    logic [3:0] v;
    v = 4'($urandom);
    set_reg(9, v);
    run_cycle("jun", 4'h4, 4'($urandom));
    run_cycle("jun_w2", 4'hB, 4'h9);
    run_cycle("ld_r9", 4'hA, 4'h9);
    checks++;
    if (acc_in !== v) begin
      errors++;
      $display("FAIL ld_r9_acc got %h exp %h", acc_in, v);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 80; i++)
      run_cycle("random", 4'($urandom), 4'($urandom));
    if (m_second) run_cycle("random_tail", 4'($urandom), 4'($urandom));
  endtask

  task automatic test_reset();
    set_reg(3, 4'hF);
    run_cycle("pre_reset_inc", 4'h7, 4'h3);
    run_cycle("pre_reset_isz_w2", 4'h0, 4'h0);
    set_reg(3, 4'hF);
    for (int p = 0; p < 7; p++) begin
      @(negedge clk);
      if (p == 3)            data_in = 4'h6;
      else if (p == 4)       data_in = 4'h3;
      else if (io === 2'b01) data_in = rf[sel];
      else                   data_in = 4'h0;
    end
    checks++;
    if (we !== 1'b1) begin
      errors++;
      $display("FAIL abort_inc_x2_we got %b exp %b", we, 1'b1);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({io, we, data_oe} !== 4'b1000) begin
      errors++;
      $display("FAIL async_we_drop got %b exp %b", {io, we, data_oe}, 4'b1000);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dut_outs() !== 16'h8000) begin
      errors++;
      $display("FAIL held_reset got %h exp %h", dut_outs(), 16'h8000);
    end
    release_reset();
    checks++;
    if (rf[3] !== 4'hF) begin
      errors++;
      $display("FAIL aborted_write got %h exp %h", rf[3], 4'hF);
    end
    run_cycle("post_reset_ld", 4'hA, 4'h3);
  endtask

  initial begin
    reset = 1'b0;
    data_in = 4'd0;
    acc_in = 4'd0;
    m_acc = 4'd0;
    m_zero = 1'b0;
    m_second = 1'b0;
    m_fopr = 4'd0;
    m_fopa = 4'd0;
    for (int i = 0; i < 16; i++) set_reg(i, 4'($urandom));
    repeat (3) @(posedge clk);
    release_reset();
    test_inc_wrap();
    test_xch();
    test_src();
    test_fim();
    test_jun_ld();
    test_back_to_back();
    test_reset();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rf[i] !== m_rf[i]) begin
        errors++;
        $display("FAIL regfile_r%0d got %h exp %h", i, rf[i], m_rf[i]);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
